encrypter_lane_scheduler: RTL and testbench
===========================================

Name: encrypter_lane_scheduler

Overview:
Shares LANES Encrypter lanes between one upstream word stream and one downstream collector. It sits between the Parallelizer output and the Collector input. It broadcasts key programming to every lane, dispatches data words round-robin to free lanes, and returns results strictly in issue order. The block is agnostic to lane flavour: basic and ADV lanes use the same handshake.

Parameters:
DATA_W, 32, word/key width (equals ENCRYPTER_WIDTH)
ROT_W, 5, rotation field width (equals KEY_ROTATION_WIDTH)
LANES, 4, number of Encrypter lanes (2..8, power of two)

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  upstream word valid
in_ready  out  1  upstream accept
in_data  in  DATA_W  key or plaintext word
in_rot  in  ROT_W  rotation for a plaintext word
in_is_key  in  1  1 = word is a new key
lane_rst  out  1  active-high synchronous reset to all lanes
lane_data  out  LANES*DATA_W  per-lane data_in_p (lane i at [i*DATA_W +: DATA_W])
lane_rot  out  LANES*ROT_W  per-lane key_rotation_p
lane_prog  out  LANES  per-lane prog_p
lane_drdy  out  LANES  per-lane data_ready_in_p
lane_ready  in  LANES  per-lane ready_p
lane_out  in  LANES*DATA_W  per-lane data_out_c
lane_ordy  in  LANES  per-lane data_ready_out_c
lane_capture  out  LANES  per-lane capture_c
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  ciphertext

Behaviour:
- Reset (reset=0, asynchronous) drives all of the following to 0: in_ready, lane_prog, lane_drdy, lane_capture, out_valid, out_data, lane_data, lane_rot, both pointers, inflight, key_loaded. lane_rst=1 while reset is low. FSM enters RST_LANES.
- Main FSM states:
  - RST_LANES: hold lane_rst=1 for 2 cycles, then go to IDLE.
  - IDLE: in_ready=1 only when in_is_key=1. Data words presented before any key are stalled, not dropped. A key is accepted on handshake and latched to lane_data of every lane; go to KEY_PROG.
  - KEY_PROG: lane_prog=all-ones with the key held for exactly 3 cycles, then deasserted. Set key_loaded=1, reset both pointers to 0, go to RUN.
  - RUN: in_ready = !in_is_key && inflight<LANES && lane_ready[disp_ptr] && no dispatch pending.
    - On accept: lane_data/lane_rot[disp_ptr] are latched and lane_drdy[disp_ptr]=1.
    - lane_drdy is held, with data stable, until lane_ready[disp_ptr] is sampled 0. It then drops.
    - After it drops: disp_ptr++ (mod LANES), inflight++.
    - If in_valid && in_is_key, go to DRAIN.
  - DRAIN: in_ready=0. When inflight==0 and out_valid==0, go to RST_LANES. The key is then accepted from IDLE, so a rekey costs at least 2+1+3 cycles.
- Collect path (independent of the main FSM, active in RUN and DRAIN):
  - If inflight>0, lane_ordy[coll_ptr]=1 and the output register is free (out_valid=0, or out_valid && out_ready this cycle):
    - out_data <= lane_out[coll_ptr]; out_valid <= 1; lane_capture[coll_ptr] <= 1.
  - lane_capture is held until lane_ordy[coll_ptr] is sampled 0. It then drops, coll_ptr++, inflight--.
  - Each result is captured once only; the capture-pending flag blocks re-capture of the same lane.
- Ordering: results leave in exactly the issue order. A later lane finishing first waits.
- out_valid/out_data hold stable until out_ready. out_valid clears on handshake unless a new capture loads the register in the same cycle.
- Simultaneous dispatch-complete and collect-complete in one cycle: inflight is unchanged.
- Wrap-around: both pointers wrap LANES-1 to 0. inflight saturates at LANES, and in_ready is 0 when full.
- Reset mid-operation: everything aborts, in-flight words are discarded, and lane_rst is asserted. A key must be reloaded.
- Lane timeout is not detected; a hung lane stalls the block.

Test Plan:
- Reset, then key 0x00000001 and word 0x000000FF with rot 4 -> one lane_prog burst of 3 cycles; out_data=0x000000EF (basic lanes).
- Key 0xA5A5A5A5, then 8 words 0..7 with rot 0 and out_ready=1 -> lanes used 0,1,2,3,0,1,2,3; outputs are i^0xA5A5A5A5 in order.
- Hold out_ready=0 while streaming 6 words -> in_ready drops after 4 dispatches plus the 1 buffered result. On release, all 6 arrive in order with no duplicates.
- Data word before any key -> in_ready=0 and no lane_drdy. A subsequent key and that word give the correct ciphertext.
- Rekey from 0x1 to 0x80000000 with 2 words in flight -> both old-key results are delivered first, then lane_rst pulses for 2 cycles. Word 0x0 with rot 1 -> 0x00000001.
- Assert reset low during lane_drdy -> all outputs are 0 asynchronously and lane_rst=1. After release, the FSM is in RST_LANES, then IDLE.

Source files
------------

// File: rtl/encrypter_lane_scheduler.sv
// rtl/encrypter_lane_scheduler.sv - shares LANES encrypter lanes between one word stream and one collector
module encrypter_lane_scheduler #(
    parameter int DATA_W = 32,
    parameter int ROT_W  = 5,
    parameter int LANES  = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [DATA_W-1:0]       i_in_data,
    input  logic [ROT_W-1:0]        i_in_rot,
    input  logic                    i_in_is_key,
    output logic                    o_lane_rst,
    output logic [LANES*DATA_W-1:0] o_lane_data,
    output logic [LANES*ROT_W-1:0]  o_lane_rot,
    output logic [LANES-1:0]        o_lane_prog,
    output logic [LANES-1:0]        o_lane_drdy,
    input  logic [LANES-1:0]        i_lane_ready,
    input  logic [LANES*DATA_W-1:0] i_lane_out,
    input  logic [LANES-1:0]        i_lane_ordy,
    output logic [LANES-1:0]        o_lane_capture,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [DATA_W-1:0]       o_out_data
);
    localparam int PTR_W = $clog2(LANES);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LANES);

    localparam logic [2:0] S_RST_LANES = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_KEY_PROG  = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_DRAIN     = 3'd4;

    logic [2:0]                     r_state;
    logic [1:0]                     r_cnt;
    logic [PTR_W-1:0]               r_disp_ptr;
    logic [PTR_W-1:0]               r_coll_ptr;
    logic [CNT_W-1:0]               r_inflight;
    logic                           r_key_loaded;
    logic                           r_disp_pend;
    logic                           r_coll_pend;
    logic [LANES-1:0][DATA_W-1:0]   r_lane_data;
    logic [LANES-1:0][ROT_W-1:0]    r_lane_rot;
    logic [LANES-1:0]               r_lane_drdy;
    logic [LANES-1:0]               r_lane_capture;
    logic                           r_out_valid;
    logic [DATA_W-1:0]              r_out_data;

    logic [LANES-1:0][DATA_W-1:0]   w_lane_out;
    logic                           w_key_acc;
    logic                           w_disp_acc;
    logic                           w_disp_done;
    logic                           w_out_free;
    logic                           w_coll_load;
    logic                           w_coll_done;

    assign w_lane_out = i_lane_out;

    always_comb begin
        o_in_ready = 1'b0;
        case (r_state)
            S_IDLE:  o_in_ready = i_in_is_key;
            S_RUN:   o_in_ready = r_key_loaded && !i_in_is_key && (r_inflight < FULL)
                                  && i_lane_ready[r_disp_ptr] && !r_disp_pend;
            default: o_in_ready = 1'b0;
        endcase
    end

    assign w_key_acc   = (r_state == S_IDLE) && i_in_valid && i_in_is_key;
    assign w_disp_acc  = (r_state == S_RUN) && i_in_valid && o_in_ready;
    assign w_disp_done = r_disp_pend && !i_lane_ready[r_disp_ptr];
    assign w_out_free  = !r_out_valid || i_out_ready;
    // Results are only taken from the oldest lane, which keeps issue order.
    assign w_coll_load = (r_inflight != '0) && !r_coll_pend && i_lane_ordy[r_coll_ptr] && w_out_free;
    assign w_coll_done = r_coll_pend && !i_lane_ordy[r_coll_ptr];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= S_RST_LANES;
            r_cnt          <= '0;
            r_disp_ptr     <= '0;
            r_coll_ptr     <= '0;
            r_inflight     <= '0;
            r_key_loaded   <= 1'b0;
            r_disp_pend    <= 1'b0;
            r_coll_pend    <= 1'b0;
            r_lane_data    <= '0;
            r_lane_rot     <= '0;
            r_lane_drdy    <= '0;
            r_lane_capture <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
        end else begin
            case (r_state)
                S_RST_LANES: begin
                    r_key_loaded <= 1'b0;
                    if (r_cnt == 2'd1) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_IDLE: begin
                    if (w_key_acc) begin
                        r_lane_data <= {LANES{i_in_data}};
                        r_cnt       <= '0;
                        r_state     <= S_KEY_PROG;
                    end
                end
                S_KEY_PROG: begin
                    if (r_cnt == 2'd2) begin
                        r_cnt        <= '0;
                        r_key_loaded <= 1'b1;
                        r_disp_ptr   <= '0;
                        r_coll_ptr   <= '0;
                        r_state      <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_RUN: begin
                    if (i_in_valid && i_in_is_key) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((r_inflight == '0) && !r_out_valid && !r_disp_pend && !r_coll_pend) begin
                        r_cnt   <= '0;
                        r_state <= S_RST_LANES;
                    end
                end
                default: r_state <= S_RST_LANES;
            endcase

            if (w_disp_acc) begin
                r_lane_data[r_disp_ptr] <= i_in_data;
                r_lane_rot[r_disp_ptr]  <= i_in_rot;
                r_lane_drdy[r_disp_ptr] <= 1'b1;
                r_disp_pend             <= 1'b1;
            end
            // The lane has taken the word once it lowers ready.
            if (w_disp_done) begin
                r_lane_drdy[r_disp_ptr] <= 1'b0;
                r_disp_pend             <= 1'b0;
                r_disp_ptr              <= r_disp_ptr + PTR_W'(1);
            end

            if (w_coll_load) begin
                r_out_data                 <= w_lane_out[r_coll_ptr];
                r_out_valid                <= 1'b1;
                r_lane_capture[r_coll_ptr] <= 1'b1;
                r_coll_pend                <= 1'b1;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_coll_done) begin
                r_lane_capture[r_coll_ptr] <= 1'b0;
                r_coll_pend                <= 1'b0;
                r_coll_ptr                 <= r_coll_ptr + PTR_W'(1);
            end

            case ({w_disp_done, w_coll_done})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign o_lane_rst     = (r_state == S_RST_LANES);
    assign o_lane_prog    = {LANES{r_state == S_KEY_PROG}};
    assign o_lane_data    = r_lane_data;
    assign o_lane_rot     = r_lane_rot;
    assign o_lane_drdy    = r_lane_drdy;
    assign o_lane_capture = r_lane_capture;
    assign o_out_valid    = r_out_valid;
    assign o_out_data     = r_out_data;
endmodule

// File: tb/tb_encrypter_lane_scheduler.sv
// tb/tb_encrypter_lane_scheduler.sv - randomized scoreboard bench for encrypter_lane_scheduler
module tb_encrypter_lane_scheduler;
    localparam int NL = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic [4:0]   in_rot = '0;
    logic         in_is_key = 1'b0;
    logic         lane_rst;
    logic [127:0] lane_data;
    logic [19:0]  lane_rot;
    logic [3:0]   lane_prog;
    logic [3:0]   lane_drdy;
    logic [3:0]   lane_ready;
    logic [127:0] lane_out;
    logic [3:0]   lane_ordy;
    logic [3:0]   lane_capture;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;

    encrypter_lane_scheduler dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
        .i_in_rot(in_rot), .i_in_is_key(in_is_key),
        .o_lane_rst(lane_rst), .o_lane_data(lane_data), .o_lane_rot(lane_rot),
        .o_lane_prog(lane_prog), .o_lane_drdy(lane_drdy), .i_lane_ready(lane_ready),
        .i_lane_out(lane_out), .i_lane_ordy(lane_ordy), .o_lane_capture(lane_capture),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] k, input logic [4:0] r);
        logic [63:0] t;
        t = {k, k} << r;
        return t[63:32];
    endfunction

    // Behavioural encrypter lanes: take a word, compute after a random delay, hand it back.
    logic [31:0] l_key [NL];
    logic [31:0] l_res [NL];
    logic [31:0] l_out [NL];
    logic        l_busy[NL];
    int          l_lat [NL];
    int          lat_max = 4;

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (lane_rst) begin
                lane_ready[i] <= 1'b1;
                lane_ordy[i]  <= 1'b0;
                l_busy[i]     <= 1'b0;
                l_key[i]      <= '0;
                l_out[i]      <= $urandom;
            end else begin
                if (lane_prog[i]) l_key[i] <= lane_data[i*32 +: 32];
                if (lane_ready[i] && lane_drdy[i]) begin
                    lane_ready[i] <= 1'b0;
                    l_busy[i]     <= 1'b1;
                    l_res[i]      <= lane_data[i*32 +: 32] ^ rotl(l_key[i], lane_rot[i*5 +: 5]);
                    l_lat[i]      <= $urandom_range(0, lat_max);
                end else if (l_busy[i]) begin
                    if (l_lat[i] == 0) begin
                        l_busy[i]    <= 1'b0;
                        lane_ordy[i] <= 1'b1;
                        l_out[i]     <= l_res[i];
                    end else begin
                        l_lat[i] <= l_lat[i] - 1;
                    end
                end else if (lane_ordy[i] && lane_capture[i]) begin
                    lane_ordy[i]  <= 1'b0;
                    lane_ready[i] <= 1'b1;
                    l_out[i]      <= $urandom;
                end
            end
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_lane_out
        assign lane_out[g*32 +: 32] = l_out[g];
    end

    // Scoreboard: expected ciphertexts in issue order, plus round-robin and pulse-length tracking.
    logic [31:0] exp_q[$];
    logic [31:0] cur_key = '0;
    logic [31:0] last_out = '0;
    logic [31:0] stall_data = '0;
    logic [127:0] prog_data = '0;
    logic        stall_prev = 1'b0;
    logic [3:0]  prev_drdy = '0;
    int          disp_idx = 0;
    int          acc_cnt = 0;
    int          out_cnt = 0;
    int          rst_len = 0;
    int          prog_len = 0;
    int          or_mode = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
            prev_drdy  = '0;
            disp_idx   = 0;
            rst_len    = 0;
            prog_len   = 0;
        end else begin
            if (in_valid && in_ready) begin
                if (in_is_key) begin
                    check_eq("drain_before_key", 32'(exp_q.size()) | 32'(out_valid), 0);
                    cur_key  = in_data;
                    disp_idx = 0;
                end else begin
                    exp_q.push_back(in_data ^ rotl(cur_key, in_rot));
                    acc_cnt++;
                end
            end
            for (int i = 0; i < NL; i++) begin
                if (lane_drdy[i] && !prev_drdy[i]) begin
                    check_eq("lane_order", 32'(i), 32'(disp_idx % NL));
                    disp_idx++;
                end
            end
            prev_drdy = lane_drdy;
            if (stall_prev) begin
                check_eq("hold_valid", 32'(out_valid), 1);
                check_eq("hold_data", out_data, stall_data);
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid && out_ready) begin
                check_eq("out_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_eq("out_data", out_data, exp_q.pop_front());
                last_out = out_data;
                out_cnt++;
            end
            if (lane_rst) begin
                rst_len++;
            end else if (rst_len != 0) begin
                check_eq("lane_rst_len", 32'(rst_len), 2);
                rst_len = 0;
            end
            if (lane_prog == 4'hF) begin
                prog_len++;
                prog_data = lane_data;
            end else if (prog_len != 0) begin
                check_eq("prog_len", 32'(prog_len), 3);
                for (int i = 0; i < NL; i++) check_eq("prog_data", prog_data[i*32 +: 32], cur_key);
                prog_len = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] r, input logic k);
        logic ok;
        ok = 1'b0;
        in_data = d; in_rot = r; in_is_key = k; in_valid = 1'b1;
        for (int n = 0; n < 3000 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        check_eq("send_accept", 32'(ok), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check_eq("drained", 32'(exp_q.size()) | 32'(out_valid), 0);
        tick(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_lane_rst"}, 32'(lane_rst), 1);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_out_data"}, out_data, 0);
        check_eq({tag, "_ctl"}, {20'd0, lane_prog, lane_drdy, lane_capture}, 0);
        check_eq({tag, "_lane_data"}, 32'(lane_data != '0) | 32'(lane_rot != '0), 0);
    endtask

    initial begin
        logic [31:0] seen;
        int acc_base;
        int out_base;
        bit sent_done;

        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // A data word before any key must stall.
        tick(4);
        in_data = 32'h0000_00FF; in_rot = 5'd4; in_is_key = 1'b0; in_valid = 1'b1;
        seen = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            seen = seen | {30'd0, (lane_drdy != 0), in_ready};
        end
        check_eq("prekey_stall", seen, 0);
        tick(1);
        in_valid = 1'b0;

        send(32'h0000_0001, 5'd0, 1'b1);
        send(32'h0000_00FF, 5'd4, 1'b0);
        wait_idle();
        check_eq("tp_basic", last_out, 32'h0000_00EF);

        // Round-robin across all lanes, twice.
        send(32'hA5A5_A5A5, 5'd0, 1'b1);
        for (int i = 0; i < 8; i++) send(32'(i), 5'd0, 1'b0);
        wait_idle();
        check_eq("tp_rr_last", last_out, 32'h0000_0007 ^ 32'hA5A5_A5A5);

        // Backpressure: four lanes plus one buffered result, then stall.
        or_mode = 1;
        tick(2);
        acc_base = acc_cnt;
        out_base = out_cnt;
        sent_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'h100 + 32'(i), 5'(i), 1'b0);
                sent_done = 1'b1;
            end
        join_none
        repeat (60) @(negedge clk);
        check_eq("stall_accepts", 32'(acc_cnt - acc_base), 5);
        check_eq("stall_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        or_mode = 0;
        for (int n = 0; n < 3000 && !sent_done; n++) tick(1);
        check_eq("stall_sender_done", 32'(sent_done), 1);
        wait_idle();
        check_eq("stall_outputs", 32'(out_cnt - out_base), 6);

        // Rekey with two words in flight.
        send(32'h0000_0001, 5'd0, 1'b1);
        or_mode = 1;
        send(32'h0000_0011, 5'd3, 1'b0);
        send(32'h0000_0022, 5'd7, 1'b0);
        fork
            begin
                tick(30);
                or_mode = 0;
            end
        join_none
        send(32'h8000_0000, 5'd0, 1'b1);
        send(32'h0000_0000, 5'd1, 1'b0);
        wait_idle();
        check_eq("tp_rekey", last_out, 32'h0000_0001);

        // Randomized traffic with occasional rekeys.
        or_mode = 2;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) send($urandom, 5'd0, 1'b1);
            else send($urandom, 5'($urandom_range(0, 31)), 1'b0);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
        end
        or_mode = 0;
        wait_idle();

        // Asynchronous reset while a dispatch is outstanding.
        in_data = 32'h1234_5678; in_rot = 5'd2; in_is_key = 1'b0; in_valid = 1'b1;
        seen = '0;
        for (int n = 0; n < 100 && seen == 0; n++) begin
            @(negedge clk);
            if (lane_drdy != 0) seen = 32'd1;
        end
        check_eq("drdy_seen", seen, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        in_valid = 1'b0;
        tick(3);
        rst_n = 1'b1;
        in_data = 32'h0F0F_0F0F; in_rot = 5'd0; in_is_key = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready0", 32'(in_ready), 0);
        @(negedge clk);
        check_eq("post_rst_ready1", 32'(in_ready), 0);
        @(negedge clk);
        check_eq("post_rst_idle", 32'(in_ready), 1);
        tick(1);
        in_valid = 1'b0;
        send(32'hFFFF_0000, 5'd8, 1'b0);
        wait_idle();
        check_eq("post_rst_out", last_out, 32'hFFFF_0000 ^ 32'h0F0F_0F0F);

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
